// File: rtl/dma_stream_bridge_if.sv
// dma_stream_bridge_if: stream signals between the DMA read-data side and the
// accelerator side of dma_stream_bridge.
//   in_data / in_valid / in_ready       : DMA word stream into the bridge
//   out_data / out_valid / out_ready    : OUT_W beat stream towards the accelerator
//   out_last                            : final beat marker (tied 0 unless enabled)
// Modports:
//   slave  : the bridge itself
//   master : the surrounding environment (DMA source plus accelerator sink)
interface dma_stream_bridge_if #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 32
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/dma_stream_bridge.sv
// dma_stream_bridge: buffers DMA words in a first-word-fall-through FIFO and
// downsizes each IN_W word into IN_W/OUT_W beats, LSB lane first. Counts a
// programmed length in output beats, pulses done_o on completion and supports
// abort (flush back to idle without done).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : start pulse, honoured only in idle; len_beats_i sampled then
//   abort_i       : flush FIFO and return to idle, highest priority
//   bus (slave)   : in_* DMA word stream, out_* beat stream, out_last
//   busy_o        : state is not idle
//   done_o        : one-cycle completion pulse
//   level_o       : FIFO occupancy in words
// Optional feature: define DMA_STREAM_LAST_EN to drive out_last on the final
// beat of a transfer; otherwise out_last is tied low.
module dma_stream_bridge #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [CNT_W-1:0]       len_beats_i,
    dma_stream_bridge_if.slave     bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned RATIO  = IN_W / OUT_W;
    localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic [IN_W-1:0]          mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]         level_q;
    logic [LANE_W-1:0]        lane_q;
    logic [CNT_W-1:0]         rem_q;

    logic                     full, empty;
    logic                     in_ready, out_valid, out_last;
    logic                     push, pop, beat, final_beat, lane_last;
    logic                     flush, load, done;
    logic [RATIO-1:0][OUT_W-1:0] head_lanes;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign lane_last = (RATIO == 1) || (lane_q == LANE_W'(RATIO - 1));
    assign head_lanes = mem[rd_ptr_q];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake decode
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        beat       = 1'b0;
        final_beat = 1'b0;
        flush      = 1'b0;
        load       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = (len_beats_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Registered-only ready: no path from out_ready.
                in_ready   = !full;
                out_valid  = !empty;
                beat       = out_valid && bus.out_ready;
                final_beat = beat && (rem_q == CNT_W'(1));
                if (final_beat) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides start, any handshake and the done pulse.
        if (abort_i) begin
            state_d    = StIdle;
            flush      = 1'b1;
            load       = 1'b0;
            beat       = 1'b0;
            final_beat = 1'b0;
            done       = 1'b0;
        end
    end

    assign push = bus.in_valid && in_ready && !abort_i;
    // Final beat pops the head even if upper lanes are unread.
    assign pop  = beat && (lane_last || final_beat);

`ifdef DMA_STREAM_LAST_EN
    assign out_last = out_valid && (rem_q == CNT_W'(1));
`else
    assign out_last = 1'b0;
`endif

    // FIFO pointers, occupancy, lane and remaining-beat counters
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lane_q   <= '0;
            rem_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
            if (load) begin
                rem_q <= len_beats_i;
            end else if (beat) begin
                rem_q <= rem_q - CNT_W'(1);
            end
            if (beat) begin
                lane_q <= (final_beat || lane_last) ? '0 : lane_q + LANE_W'(1);
            end
        end
    end

    // Storage carries no reset; out_data is gated so it reads 0 when invalid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head_lanes[lane_q] : '0;
    assign bus.out_last  = out_last;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done;
    assign level_o       = level_q;

endmodule
